// File: rtl/sumador_serie.sv
// sumador_serie: bit-serial adder/subtractor, one bit per clock LSB first,
// parallel operands in and parallel result out through valid/ready handshakes.
module semisumador (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module sumador_serie #(
  parameter int ANCHO = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valido,
  output logic             o_listo,
  input  logic [ANCHO-1:0] i_operando_a,
  input  logic [ANCHO-1:0] i_operando_b,
  input  logic             i_restar,
  output logic             o_valido,
  input  logic             i_listo,
  output logic [ANCHO-1:0] o_suma,
  output logic             o_acarreo
);
  localparam int CW = $clog2(ANCHO);
  typedef enum logic [1:0] {REPOSO, CALCULO, RESULTADO} estado_t;
  estado_t          r_estado;
  logic [ANCHO-1:0] r_a, r_b, r_suma;
  logic             r_acarreo;
  logic [CW-1:0]    r_cnt;
  logic             w_p, w_c1, w_s, w_c2;
  // Full adder from two half-adder cells; the carry flop closes the loop.
  semisumador u_ha1 (.i_x(r_a[0]), .i_y(r_b[0]),    .o_s(w_p), .o_c(w_c1));
  semisumador u_ha2 (.i_x(w_p),    .i_y(r_acarreo), .o_s(w_s), .o_c(w_c2));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_estado  <= REPOSO;
      r_a       <= '0;
      r_b       <= '0;
      r_suma    <= '0;
      r_acarreo <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_estado)
        REPOSO: if (i_valido) begin
          r_a       <= i_operando_a;
          r_b       <= i_operando_b ^ {ANCHO{i_restar}};
          r_acarreo <= i_restar;
          r_cnt     <= '0;
          r_estado  <= CALCULO;
        end
        CALCULO: begin
          r_suma    <= {w_s, r_suma[ANCHO-1:1]};
          r_a       <= r_a >> 1;
          r_b       <= r_b >> 1;
          r_acarreo <= w_c1 | w_c2;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CW'(ANCHO - 1)) r_estado <= RESULTADO;
        end
        RESULTADO: if (i_listo) r_estado <= REPOSO;
        default: r_estado <= REPOSO;
      endcase
    end
  end
  assign o_listo   = r_estado == REPOSO;
  assign o_valido  = r_estado == RESULTADO;
  assign o_suma    = r_suma;
  assign o_acarreo = r_acarreo;
endmodule

// File: tb/tb_sumador_serie.sv
// tb_sumador_serie: directed and randomized checks of sumador_serie at ANCHO=8 and ANCHO=2
// against an arithmetic reference model with a countdown timing model.
module tb_sumador_serie;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v8, ol8, r8, ov8, l8, c8;
  logic [7:0] a8, b8, s8;
  logic v2, ol2, r2, ov2, l2, c2;
  logic [1:0] a2, b2, s2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sumador_serie #(.ANCHO(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valido(v8), .o_listo(ol8),
    .i_operando_a(a8), .i_operando_b(b8), .i_restar(r8),
    .o_valido(ov8), .i_listo(l8), .o_suma(s8), .o_acarreo(c8)
  );

  sumador_serie #(.ANCHO(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valido(v2), .o_listo(ol2),
    .i_operando_a(a2), .i_operando_b(b2), .i_restar(r2),
    .o_valido(ov2), .i_listo(l2), .o_suma(s2), .o_acarreo(c2)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Result of A op B in w bits: low w bits are the sum, bit w is carry (add) or no-borrow (sub).
  function automatic logic [32:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic r);
    longint m, t;
    m = longint'(1) << w;
    t = r ? (longint'(a) - longint'(b) + m) : (longint'(a) + longint'(b));
    ref_op = {t >= m, 32'(t % m)};
  endfunction

  // Model: 0 idle, 1 computing (cnt cycles left), 2 holding result.
  int st8 = 0, cnt8 = 0, st2 = 0, cnt2 = 0;
  logic [32:0] e8 = '0, e2 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st8 <= 0;
      st2 <= 0;
    end else begin
      if (st8 == 0 && v8) begin
        st8 <= 1; cnt8 <= 8; e8 <= ref_op(8, 32'(a8), 32'(b8), r8);
      end else if (st8 == 1) begin
        cnt8 <= cnt8 - 1;
        if (cnt8 == 1) st8 <= 2;
      end else if (st8 == 2 && l8) st8 <= 0;
      if (st2 == 0 && v2) begin
        st2 <= 1; cnt2 <= 2; e2 <= ref_op(2, 32'(a2), 32'(b2), r2);
      end else if (st2 == 1) begin
        cnt2 <= cnt2 - 1;
        if (cnt2 == 1) st2 <= 2;
      end else if (st2 == 2 && l2) st2 <= 0;
    end
  end

  int cyc = 0, t2 = 0, res2 = 0;
  logic p2 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("listo8", 32'(ol8), 32'(st8 == 0));
      chk("valido8", 32'(ov8), 32'(st8 == 2));
      if (st8 == 2) begin
        chk("suma8", 32'(s8), 32'(e8[7:0]));
        chk("acarreo8", 32'(c8), 32'(e8[32]));
      end
      chk("listo2", 32'(ol2), 32'(st2 == 0));
      chk("valido2", 32'(ov2), 32'(st2 == 2));
      if (st2 == 2) begin
        chk("suma2", 32'(s2), 32'(e2[1:0]));
        chk("acarreo2", 32'(c2), 32'(e2[32]));
      end
      if (ov2 && !p2) begin
        if (res2 > 0) chk("intervalo2", 32'(cyc - t2), 32'd4);
        t2 = cyc;
        res2++;
      end
    end
    p2 = ov2;
    cyc++;
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic r,
                      input logic [7:0] es, input logic ec, input int espera,
                      input logic ruido, input string n);
    int k;
    @(negedge clk);
    a8 = a; b8 = b; r8 = r; v8 = 1'b1; l8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); r8 = 1'($urandom);
    k = 0;
    while (!ov8 && k < 30) begin
      if (ruido && k == 3) begin
        v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end else v8 = 1'b0;
      @(negedge clk);
      k++;
    end
    v8 = 1'b0;
    chk({n, "_latencia"}, 32'(k), 32'd8);
    chk({n, "_suma"}, 32'(s8), 32'(es));
    chk({n, "_acarreo"}, 32'(c8), 32'(ec));
    repeat (espera) begin
      @(negedge clk);
      chk({n, "_retiene_valido"}, 32'(ov8), 32'd1);
      chk({n, "_retiene_suma"}, 32'(s8), 32'(es));
      chk({n, "_retiene_acarreo"}, 32'(c8), 32'(ec));
    end
    l8 = 1'b1;
    @(negedge clk);
    l8 = 1'b0;
    chk({n, "_reposo"}, 32'(ol8), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    v8 = 0; l8 = 0; a8 = 0; b8 = 0; r8 = 0;
    v2 = 0; l2 = 1; a2 = 0; b2 = 0; r2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_listo8", 32'(ol8), 32'd1);
    chk("rst_valido8", 32'(ov8), 32'd0);
    chk("rst_suma8", 32'(s8), 32'd0);
    chk("rst_acarreo8", 32'(c8), 32'd0);
    chk("rst_listo2", 32'(ol2), 32'd1);
    chk("rst_valido2", 32'(ov2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, 1'b0, "suma_0f_01");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0, "suma_ff_01");
    run8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0, 1'b0, "suma_ff_ff");
    run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0, 1'b0, "resta_05_07");
    run8(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0, 1'b0, "resta_07_05");
    run8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 5, 1'b0, "contrapresion");
    run8(8'h81, 8'h7F, 1'b0, 8'h00, 1'b1, 0, 1'b1, "ocupado");
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; r8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_medio_listo", 32'(ol8), 32'd1);
    chk("rst_medio_valido", 32'(ov8), 32'd0);
    chk("rst_medio_suma", 32'(s8), 32'd0);
    chk("rst_medio_acarreo", 32'(c8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 1'b0, "tras_reset");
    repeat (800) begin
      @(negedge clk);
      v8 = 1'($urandom); l8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); r8 = 1'($urandom);
    end
    v8 = 1'b0; l8 = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      {r2, a2, b2} = 5'(i);
      v2 = 1'b1;
      for (int w = 0; w < 10 && !ol2; w++) @(negedge clk);
      @(negedge clk);
    end
    v2 = 1'b0;
    repeat (8) @(negedge clk);
    chk("resultados2", 32'(res2), 32'd32);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sumador_serie.md
# sumador_serie

Bit-serial adder/subtractor. It accepts two `ANCHO`-bit operands in parallel and processes one bit per clock, LSB first. Each bit goes through a one-bit full adder built from two half-adder cells plus a carry flip-flop. It returns the parallel result and the final carry through a valid/ready handshake. It sits in the arithmetic examples as the sequential consumer of the half-adder cell: it produces operand pairs internally and accumulates sum/carry outputs over time.

## Interface
- `ANCHO`, 8, operand and result width in bits; legal range 2..32.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_valido`  in  1  input request; operands and mode are valid this cycle.
- `o_listo`  out  1  block accepts a request this cycle.
- `i_operando_a`  in  ANCHO  operand A, unsigned.
- `i_operando_b`  in  ANCHO  operand B, unsigned.
- `i_restar`  in  1  0 = A+B, 1 = A−B (two's complement); sampled with the request.
- `o_valido`  out  1  result valid.
- `i_listo`  in  1  downstream accepts the result.
- `o_suma`  out  ANCHO  result bits.
- `o_acarreo`  out  1  final carry out of the MSB.

## Operation
- FSM states:
  - `REPOSO`: `o_listo`=1.
  - `CALCULO`: `o_listo`=0, `o_valido`=0.
  - `RESULTADO`: `o_valido`=1.
- Acceptance happens on an edge with `REPOSO` && `i_valido`. On that edge the block loads:
  - shift register A ← `i_operando_a`;
  - shift register B ← `i_operando_b` XOR {ANCHO{`i_restar`}};
  - carry ← `i_restar`;
  - bit counter ← 0;
  - state ← `CALCULO`.
- Each `CALCULO` cycle computes the current bit:
  - p = A[0]^B[0]; s = p^carry; carry' = (A[0]&B[0]) | (p&carry).
  - s shifts into the result register from the MSB side; A and B shift right; counter increments.
- When the counter reaches ANCHO−1 (i.e. on the ANCHO-th `CALCULO` edge), state ← `RESULTADO`. At that point `o_suma` = full result and `o_acarreo` = final carry.
- In `RESULTADO`, `o_suma` and `o_acarreo` hold stable until `i_valido`... specifically until `o_valido` && `i_listo` on an edge; that edge moves the state to `REPOSO`.
- Subtraction: `o_acarreo`=1 means no borrow (A≥B); `o_acarreo`=0 means borrow. The result wraps modulo 2^ANCHO in both modes.
- `i_valido` outside `REPOSO` is ignored. No queueing, no error flag.
- `o_listo` and `o_valido` are decoded from state only and are never combinational from inputs.
- Operand and mode inputs are sampled only on the acceptance edge. Later changes have no effect.
- `o_suma` shows the shifting partial result during `CALCULO`. Downstream qualifies it with `o_valido` only.

## Timing
- Reset (`i_rst_n`=0, asynchronous) sets:
  - state `REPOSO`, so `o_listo`=1 and `o_valido`=0;
  - `o_suma`=0, `o_acarreo`=0, counter=0, A/B shift registers=0.
- Release is synchronous to the next `i_clk` rising edge.
- Latency: if a request is accepted on edge k, `o_valido` rises after edge k+ANCHO.
- Throughput: at best one operation per ANCHO+2 cycles. There is a mandatory `REPOSO` cycle between consecutive results; `o_listo` is not asserted in `RESULTADO`.
- Backpressure: `i_listo`=0 holds `RESULTADO` indefinitely with outputs frozen.
- Reset mid-operation (`CALCULO` or `RESULTADO`): the operation is discarded, no `o_valido` pulse, and outputs return to reset values immediately.
- `i_valido` held high continuously: one acceptance per `REPOSO` visit.

## Test plan
- ANCHO=8, add 0x0F+0x01 -> `o_valido` after exactly 8 cycles, `o_suma`=0x10, `o_acarreo`=0.
- ANCHO=8, add 0xFF+0x01 -> `o_suma`=0x00, `o_acarreo`=1. Also 0xFF+0xFF -> `o_suma`=0xFE, `o_acarreo`=1.
- ANCHO=8, subtract 0x05−0x07 -> `o_suma`=0xFE, `o_acarreo`=0. Then 0x07−0x05 -> `o_suma`=0x02, `o_acarreo`=1.
- Backpressure and busy handling:
  - hold `i_listo`=0 for 5 cycles after `o_valido` -> `o_suma`/`o_acarreo` unchanged, `o_valido` stays 1;
  - pulse `i_valido` with new operands during `CALCULO` -> ignored, first result unaffected.
- Assert `i_rst_n`=0 three cycles into `CALCULO` -> outputs 0 and `o_listo`=1 immediately. After release, a fresh request 0x12+0x34 -> `o_suma`=0x46, `o_acarreo`=0.
- ANCHO=2, all 32 combinations of A, B and `i_restar`, back-to-back with `i_valido`/`i_listo` tied high -> every result matches a reference model, with exactly 4 cycles between results.
